msm_point_accumulator: RTL and testbench

MSM_POINT_ACCUMULATOR -- requirements
Module: msm_point_accumulator

---
 rtl/msm_point_accumulator_if.sv | 60 ++++++
 rtl/msm_point_accumulator.sv | 220 ++++++++++++++++++++++
 tb/tb_msm_point_accumulator.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msm_point_accumulator_if.sv
// ---------------------------------------------------------------------------
// msm_point_accumulator_if
//
// Purpose: shared point type plus the handshake bundle between the MSM point
// accumulator and its neighbours (upstream point multiplier, downstream sink,
// and the controller that requests an accumulation).
//
// msm_point_accumulator_pkg
//   curve_point_t : {inf, x, y}. inf=1 marks the point at infinity (group
//                   identity); the only encoding of it is INF_POINT.
//   INF_POINT     : canonical point at infinity (inf=1, x=0, y=0).
//
// msm_point_accumulator_if #(COUNT_W)
//   start, num_points     : request a new sum of num_points points
//   in_valid/in_ready     : point stream from the multiplier (in_point)
//   out_valid/out_ready   : final sum to the sink (out_sum)
//   busy                  : accumulator is not idle
//   modport master        : requester / stream source / sink side
//   modport slave         : accumulator side
// ---------------------------------------------------------------------------
package msm_point_accumulator_pkg;

    localparam int COORD_W = 16;

    typedef struct packed {
        logic               inf;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } curve_point_t;

    localparam curve_point_t INF_POINT = '{inf: 1'b1, x: '0, y: '0};

endpackage

interface msm_point_accumulator_if #(
    parameter int COUNT_W = 16
) ();
    import msm_point_accumulator_pkg::*;

    logic               start;
    logic [COUNT_W-1:0] num_points;
    logic               in_valid;
    logic               in_ready;
    curve_point_t       in_point;
    logic               out_valid;
    logic               out_ready;
    curve_point_t       out_sum;
    logic               busy;

    modport master (
        output start, num_points, in_valid, in_point, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  start, num_points, in_valid, in_point, out_ready,
        output in_ready, out_valid, out_sum, busy
    );

endinterface

// File: rtl/msm_point_accumulator.sv
// ---------------------------------------------------------------------------
// msm_point_accumulator
//
// Purpose: sums a stream of curve points (products from an upstream point
// multiplier) into one result for a multi-scalar multiplication. One shared
// multi-cycle point_add unit performs every addition; the running sum lives
// in acc and is always visible on out_sum.
//
// Ports:
//   clk      : sole clock, rising edge
//   Reset_n  : asynchronous active-low reset; discards any in-flight work
//   bus      : msm_point_accumulator_if.slave
//              start/num_points   - accumulation request (sampled in IDLE)
//              in_valid/in_ready  - point input handshake (in_point)
//              out_valid/out_ready- result handshake (out_sum)
//              busy               - high in every state except IDLE
//
// Optional build macro:
//   MSM_ACC_INF_BYPASS_EN - when defined, a point whose addition is trivial
//   (running sum or incoming point is the point at infinity) is folded into
//   acc on the handshake edge without using the adder.
//
// point_add (also in this file) is a stand-in adder with the real unit's
// protocol: Reset high for a cycle starts an addition, Done rises ADD_CYCLES
// edges after Reset is released and holds until the next Reset. Its group
// law treats INF_POINT as identity and otherwise adds coordinates modulo
// 2^COORD_W.
// ---------------------------------------------------------------------------
module point_add
    import msm_point_accumulator_pkg::*;
#(
    parameter int ADD_CYCLES = 4
) (
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    input  curve_point_t Q,
    output curve_point_t R,
    output logic         Done
);

    localparam int CNT_W = $clog2(ADD_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    function automatic curve_point_t group_add(input curve_point_t a, input curve_point_t b);
        curve_point_t s;
        if (a.inf) begin
            s = b;
        end else if (b.inf) begin
            s = a;
        end else begin
            s.inf = 1'b0;
            s.x   = a.x + b.x;
            s.y   = a.y + b.y;
        end
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt  <= '0;
            Done <= 1'b0;
        end else if (!Done) begin
            if (cnt == CNT_W'(ADD_CYCLES - 1)) begin
                R    <= group_add(P, Q);
                Done <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

module msm_point_accumulator
    import msm_point_accumulator_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                   clk,
    input  logic                   Reset_n,
    msm_point_accumulator_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        ADD_RST,
        ADD_RUN,
        OUTPUT
    } state_t;

    state_t             state;
    curve_point_t       acc;
    curve_point_t       q;
    logic [COUNT_W-1:0] remaining;
    logic               in_ready;
    logic               out_valid;
    logic               busy;

    logic               add_reset;
    logic               add_done;
    curve_point_t       add_r;

    // Registered handshake flags {busy, in_ready, out_valid} for a state,
    // loaded together with the state so they never lag it.
    function automatic logic [2:0] flags_for(input state_t s);
        return {s != IDLE, s == WAIT_IN, s == OUTPUT};
    endfunction

    // Where to go once a point has been folded into acc; rem is the count
    // before this point is retired.
    function automatic state_t after_point(input logic [COUNT_W-1:0] rem);
        return (rem == COUNT_W'(1)) ? OUTPUT : WAIT_IN;
    endfunction

    // Count down without ever wrapping below zero.
    function automatic logic [COUNT_W-1:0] dec_sat(input logic [COUNT_W-1:0] rem);
        return (rem != '0) ? rem - 1'b1 : '0;
    endfunction

    // The adder is held in reset while the block is reset, and pulsed for
    // exactly the ADD_RST cycle to launch each addition.
    assign add_reset = (state == ADD_RST) || !Reset_n;

    point_add u_add (
        .clk   (clk),
        .Reset (add_reset),
        .P     (acc),
        .Q     (q),
        .R     (add_r),
        .Done  (add_done)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            acc       <= INF_POINT;
            q         <= INF_POINT;
            remaining <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc       <= INF_POINT;
                        remaining <= bus.num_points;
                        if (bus.num_points == '0) begin
                            state                        <= OUTPUT;
                            {busy, in_ready, out_valid}  <= flags_for(OUTPUT);
                        end else begin
                            state                        <= WAIT_IN;
                            {busy, in_ready, out_valid}  <= flags_for(WAIT_IN);
                        end
                    end
                end

                // Input handshake stage
                WAIT_IN: begin
                    if (bus.in_valid) begin
`ifdef MSM_ACC_INF_BYPASS_EN
                        if ((acc == INF_POINT) || (bus.in_point == INF_POINT)) begin
                            acc                          <= (acc == INF_POINT) ? bus.in_point : acc;
                            remaining                    <= dec_sat(remaining);
                            state                        <= after_point(remaining);
                            {busy, in_ready, out_valid}  <= flags_for(after_point(remaining));
                        end else begin
                            q                            <= bus.in_point;
                            state                        <= ADD_RST;
                            {busy, in_ready, out_valid}  <= flags_for(ADD_RST);
                        end
`else
                        q                            <= bus.in_point;
                        state                        <= ADD_RST;
                        {busy, in_ready, out_valid}  <= flags_for(ADD_RST);
`endif
                    end
                end

                // Adder launch stage
                ADD_RST: begin
                    state                        <= ADD_RUN;
                    {busy, in_ready, out_valid}  <= flags_for(ADD_RUN);
                end

                // Adder completion stage
                ADD_RUN: begin
                    if (add_done) begin
                        acc                          <= add_r;
                        remaining                    <= dec_sat(remaining);
                        state                        <= after_point(remaining);
                        {busy, in_ready, out_valid}  <= flags_for(after_point(remaining));
                    end
                end

                // Result hold stage: acc stays frozen until the sink takes it
                OUTPUT: begin
                    if (bus.out_ready) begin
                        state                        <= IDLE;
                        {busy, in_ready, out_valid}  <= flags_for(IDLE);
                    end
                end

                default: begin
                    state                        <= IDLE;
                    {busy, in_ready, out_valid}  <= flags_for(IDLE);
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = acc;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_msm_point_accumulator.sv
// ---------------------------------------------------------------------------
// tb_msm_point_accumulator
//
// Self-checking bench for msm_point_accumulator. Expected sums come from a
// set-level model: the sum of a list of points is the point at infinity when
// every point is at infinity, otherwise the coordinate-wise sum (mod 2^16)
// of the finite points. Expected adder launches and latencies come from
// counting which points need a real addition.
// ---------------------------------------------------------------------------
module tb_msm_point_accumulator;
    import msm_point_accumulator_pkg::*;

    localparam int COUNT_W    = 16;
    localparam int ADD_CYCLES = 4;      // point_add default latency
    localparam int LIMIT      = 2000;   // cycle budget for any wait

    logic clk = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    msm_point_accumulator_if #(.COUNT_W(COUNT_W)) bus ();

    msm_point_accumulator #(.COUNT_W(COUNT_W)) dut (
        .clk     (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    // ---------------- reference model ----------------
    function automatic curve_point_t model_sum(input curve_point_t pts[$]);
        curve_point_t s;
        bit           any_finite = 1'b0;
        int unsigned  sx = 0;
        int unsigned  sy = 0;
        foreach (pts[i]) begin
            if (!pts[i].inf) begin
                any_finite = 1'b1;
                sx += pts[i].x;
                sy += pts[i].y;
            end
        end
        if (!any_finite) return INF_POINT;
        s.inf = 1'b0;
        s.x   = COORD_W'(sx);
        s.y   = COORD_W'(sy);
        return s;
    endfunction

    // Number of points that must go through the adder.
    function automatic int model_adds(input curve_point_t pts[$]);
        int n = 0;
        bit sum_is_inf = 1'b1;
        foreach (pts[i]) begin
`ifdef MSM_ACC_INF_BYPASS_EN
            if (!(sum_is_inf || pts[i].inf)) n++;
`else
            n++;
`endif
            if (!pts[i].inf) sum_is_inf = 1'b0;
        end
        return n;
    endfunction

    // Cycles from the start cycle to out_valid with in_valid always high:
    // one cycle to enter WAIT_IN, then per point either the bypass edge or
    // handshake + ADD_RST + (ADD_CYCLES + 1) cycles waiting on Done.
    function automatic int model_latency(input curve_point_t pts[$]);
        int adds = model_adds(pts);
        return 1 + adds * (3 + ADD_CYCLES) + (pts.size() - adds);
    endfunction

    function automatic curve_point_t rand_point();
        curve_point_t p;
        p.inf = 1'b0;
        p.x   = COORD_W'($urandom);
        p.y   = COORD_W'($urandom);
        return p;
    endfunction

    // ---------------- stimulus driver (no checking) ----------------
    // Called just after a rising edge with the DUT idle. Requests an
    // accumulation of n points, offers pts (then junk) on the input, and
    // returns at the falling edge where out_valid is seen.
    task automatic run_job(input curve_point_t pts[$], input int n, input bit alt,
                           output curve_point_t sum, output int hs, output int cyc,
                           output int resets, output bit to);
        bit phase = 1'b1;
        int idx   = 0;
        hs = 0; cyc = 0; resets = 0; to = 1'b0; sum = INF_POINT;
        bus.start      = 1'b1;
        bus.num_points = COUNT_W'(n);
        forever begin
            bus.in_valid = !alt || phase;
            bus.in_point = (idx < pts.size()) ? pts[idx] : rand_point();
            phase = !phase;
            @(negedge clk);
            if (bus.out_valid) begin
                sum = bus.out_sum;
                break;
            end
            if (bus.in_valid && bus.in_ready) begin
                hs++;
                idx++;
            end
            if (dut.add_reset) resets++;
            cyc++;
            if (cyc > LIMIT) begin
                to = 1'b1;
                break;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.num_points = '0;
        bus.in_valid   = 1'b0;
        bus.in_point   = INF_POINT;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_sum !== INF_POINT) begin errors++; $display("FAIL reset out_sum: got %h want %h", bus.out_sum, INF_POINT); end
        checks++; if (dut.add_reset !== 1'b1) begin errors++; $display("FAIL reset adder_reset: got %b want 1", dut.add_reset); end
        Reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset idle_after_release busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_three_g();
        curve_point_t pts[$];
        curve_point_t g, sum;
        int hs, cyc, resets;
        bit to;
        g = rand_point();
        pts.push_back(g); pts.push_back(g); pts.push_back(g);
        run_job(pts, 3, 1'b0, sum, hs, cyc, resets, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL three_g timeout: got %b want 0", to); end
        checks++; if (sum !== model_sum(pts)) begin errors++; $display("FAIL three_g sum: got %h want %h", sum, model_sum(pts)); end
        checks++; if (hs !== 3) begin errors++; $display("FAIL three_g handshakes: got %0d want 3", hs); end
        checks++; if (cyc !== model_latency(pts)) begin errors++; $display("FAIL three_g latency: got %0d want %0d", cyc, model_latency(pts)); end
        checks++; if (resets !== model_adds(pts)) begin errors++; $display("FAIL three_g adder_launches: got %0d want %0d", resets, model_adds(pts)); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL three_g idle_after: got busy %b want 0", bus.busy); end
    endtask

    task automatic test_zero_points();
        curve_point_t pts[$];
        curve_point_t sum;
        int hs, cyc, resets;
        bit to;
        run_job(pts, 0, 1'b0, sum, hs, cyc, resets, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero timeout: got %b want 0", to); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL zero latency: got %0d want 1", cyc); end
        checks++; if (sum !== INF_POINT) begin errors++; $display("FAIL zero sum: got %h want %h", sum, INF_POINT); end
        checks++; if (hs !== 0) begin errors++; $display("FAIL zero handshakes (in_ready seen): got %0d want 0", hs); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL zero in_ready: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_out_stall();
        curve_point_t pts[$];
        curve_point_t sum, want;
        int hs, cyc, resets, bad_valid, bad_sum, bad_ready;
        bit to;
        pts.push_back(rand_point());
        pts.push_back(rand_point());
        want = model_sum(pts);
        bus.out_ready = 1'b0;
        run_job(pts, 2, 1'b0, sum, hs, cyc, resets, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL stall timeout: got %b want 0", to); end
        checks++; if (sum !== want) begin errors++; $display("FAIL stall sum: got %h want %h", sum, want); end
        bad_valid = 0; bad_sum = 0; bad_ready = 0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.start      = (i == 3);
            bus.num_points = '0;
            @(negedge clk);
            if (bus.out_valid !== 1'b1) bad_valid++;
            if (bus.out_sum !== want) bad_sum++;
            if (bus.in_ready !== 1'b0) bad_ready++;
        end
        checks++; if (bad_valid !== 0) begin errors++; $display("FAIL stall out_valid_dropped: got %0d cycles want 0", bad_valid); end
        checks++; if (bad_sum !== 0) begin errors++; $display("FAIL stall out_sum_changed: got %0d cycles want 0", bad_sum); end
        checks++; if (bad_ready !== 0) begin errors++; $display("FAIL stall in_ready_high: got %0d cycles want 0", bad_ready); end
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall release out_valid: got %b want 0", bus.out_valid); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall start_ignored busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_alternating();
        curve_point_t pts[$];
        curve_point_t g, sum;
        int hs, cyc, resets;
        bit to;
        g = rand_point();
        pts.push_back(g);
        pts.push_back(model_sum('{g, g}));
        run_job(pts, 2, 1'b1, sum, hs, cyc, resets, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL alternating timeout: got %b want 0", to); end
        checks++; if (hs !== 2) begin errors++; $display("FAIL alternating handshakes: got %0d want 2", hs); end
        checks++; if (sum !== model_sum(pts)) begin errors++; $display("FAIL alternating sum: got %h want %h", sum, model_sum(pts)); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_add();
        curve_point_t pts[3];
        curve_point_t one[$];
        curve_point_t sum;
        int idx, hs, cyc, resets, seen_valid, seen_busy;
        bit found, to;
        for (int i = 0; i < 3; i++) pts[i] = rand_point();
        idx = 0; found = 1'b0;
        bus.start = 1'b1; bus.num_points = COUNT_W'(2);
        bus.in_valid = 1'b1; bus.in_point = pts[0];
        for (int c = 0; c < LIMIT && !found; c++) begin
            @(negedge clk);
            if (dut.add_reset) found = 1'b1;
            else if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
            bus.start    = 1'b0;
            bus.in_point = pts[(idx < 2) ? idx : 2];
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL midreset reach_add_run: got %b want 1", found); end
        // now in ADD_RUN; assert reset away from any clock edge
        #2;
        Reset_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midreset in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b want 0", bus.busy); end
        checks++; if (bus.out_sum !== INF_POINT) begin errors++; $display("FAIL midreset out_sum: got %h want %h", bus.out_sum, INF_POINT); end
        checks++; if (dut.add_reset !== 1'b1) begin errors++; $display("FAIL midreset adder_reset: got %b want 1", dut.add_reset); end
        repeat (2) @(posedge clk);
        #1;
        Reset_n = 1'b1;
        seen_valid = 0; seen_busy = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen_valid++;
            if (bus.busy !== 1'b0) seen_busy++;
        end
        bus.in_valid = 1'b0;
        checks++; if (seen_valid !== 0) begin errors++; $display("FAIL midreset stray_out_valid: got %0d cycles want 0", seen_valid); end
        checks++; if (seen_busy !== 0) begin errors++; $display("FAIL midreset stray_busy: got %0d cycles want 0", seen_busy); end
        @(posedge clk); #1;
        one.push_back(pts[2]);
        run_job(one, 1, 1'b0, sum, hs, cyc, resets, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL midreset restart timeout: got %b want 0", to); end
        checks++; if (sum !== pts[2]) begin errors++; $display("FAIL midreset restart sum: got %h want %h", sum, pts[2]); end
        checks++; if (hs !== 1) begin errors++; $display("FAIL midreset restart handshakes: got %0d want 1", hs); end
        @(posedge clk); #1;
    endtask

    task automatic test_first_point();
        curve_point_t g, h, want_after, sum;
        bit want_rst, done;
        g = rand_point();
        h = rand_point();
`ifdef MSM_ACC_INF_BYPASS_EN
        want_after = g;
        want_rst   = 1'b0;
`else
        want_after = INF_POINT;
        want_rst   = 1'b1;
`endif
        bus.start = 1'b1; bus.num_points = COUNT_W'(2);
        bus.in_valid = 1'b1; bus.in_point = g;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL first_point in_ready: got %b want 1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_point = h;
        @(negedge clk);
        checks++; if (bus.out_sum !== want_after) begin errors++; $display("FAIL first_point acc_after_handshake: got %h want %h", bus.out_sum, want_after); end
        checks++; if (dut.add_reset !== want_rst) begin errors++; $display("FAIL first_point adder_reset: got %b want %b", dut.add_reset, want_rst); end
        done = 1'b0; sum = INF_POINT;
        for (int c = 0; c < LIMIT && !done; c++) begin
            if (bus.out_valid) begin
                done = 1'b1;
                sum  = bus.out_sum;
            end else begin
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL first_point timeout: got %b want 1", done); end
        checks++; if (sum !== model_sum('{g, h})) begin errors++; $display("FAIL first_point sum: got %h want %h", sum, model_sum('{g, h})); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        curve_point_t pts[$];
        curve_point_t sum, want;
        int n, hs, cyc, resets;
        bit alt, to;
        for (int job = 0; job < 10; job++) begin
            pts.delete();
            n   = $urandom_range(1, 5);
            alt = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) pts.push_back(INF_POINT);
                else pts.push_back(rand_point());
            end
            want = model_sum(pts);
            run_job(pts, n, alt, sum, hs, cyc, resets, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL random[%0d] timeout: got %b want 0", job, to); end
            checks++; if (sum !== want) begin errors++; $display("FAIL random[%0d] sum: got %h want %h", job, sum, want); end
            checks++; if (hs !== n) begin errors++; $display("FAIL random[%0d] handshakes: got %0d want %0d", job, hs, n); end
            checks++; if (resets !== model_adds(pts)) begin errors++; $display("FAIL random[%0d] adder_launches: got %0d want %0d", job, resets, model_adds(pts)); end
            if (!alt) begin
                checks++; if (cyc !== model_latency(pts)) begin errors++; $display("FAIL random[%0d] latency: got %0d want %0d", job, cyc, model_latency(pts)); end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_three_g();
        test_zero_points();
        test_out_stall();
        test_alternating();
        test_reset_mid_add();
        test_first_point();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

endmodule
